// File: rtl/gci_irq_arbiter_n_pkg.sv
// Shared types and mode encodings for the GCI interrupt arbiter.
// Control entries are {mask, valid, mode}; mode[1] is reserved but kept.
package gci_irq_arbiter_n_pkg;

    localparam logic [1:0] IRQ_MODE_LEVEL = 2'h0;
    localparam logic [1:0] IRQ_MODE_EDGE  = 2'h1;

    typedef struct packed {
        logic       mask;
        logic       valid;
        logic [1:0] mode;
    } irq_ctrl_t;

    function automatic logic isEdgeMode(input irq_ctrl_t entry);
        return entry.mode[0] == IRQ_MODE_EDGE[0];
    endfunction

    // An entry that was never validated leaves its node permanently enabled.
    function automatic logic isEnabled(input irq_ctrl_t entry);
        return !entry.valid || entry.mask;
    endfunction

endpackage

// File: rtl/gci_irq_arbiter_n_if.sv
// CPU-side bus of the arbiter: control-memory write port and IRQ-number queue port.
interface gci_irq_arbiter_n_if #(
    parameter int P_ENTRY_W = 5,
    parameter int P_NUM_W   = 6
) ();
    logic                 irqCtrlReq;
    logic [P_ENTRY_W-1:0] irqCtrlEntry;
    logic                 irqCtrlInfoMask;
    logic                 irqCtrlInfoValid;
    logic [1:0]           irqCtrlInfoMode;
    logic                 irqEmpty;
    logic                 irqValid;
    logic [P_NUM_W-1:0]   irqNum;
    logic                 irqAck;

    modport master (
        output irqCtrlReq, irqCtrlEntry, irqCtrlInfoMask, irqCtrlInfoValid, irqCtrlInfoMode, irqAck,
        input  irqEmpty, irqValid, irqNum
    );

    modport slave (
        input  irqCtrlReq, irqCtrlEntry, irqCtrlInfoMask, irqCtrlInfoValid, irqCtrlInfoMode, irqAck,
        output irqEmpty, irqValid, irqNum
    );
endinterface

// File: rtl/gci_irq_arbiter_n_queue.sv
// Synchronous FIFO of granted IRQ numbers; power-of-two depth so pointers wrap naturally.
module gci_irq_arbiter_n_queue #(
    parameter int P_WIDTH = 6,
    parameter int P_DEPTH = 4
) (
    input  logic                       iCLOCK,
    input  logic                       inRESET,
    input  logic                       iPUSH,
    input  logic [P_WIDTH-1:0]         iDATA,
    input  logic                       iPOP,
    output logic [P_WIDTH-1:0]         oDATA,
    output logic                       oFULL,
    output logic                       oEMPTY,
    output logic [$clog2(P_DEPTH):0]   oCOUNT
);
    localparam int PTR_W = $clog2(P_DEPTH);

    logic [P_DEPTH-1:0][P_WIDTH-1:0] mem_r;
    logic [PTR_W-1:0]                wrPtr_r;
    logic [PTR_W-1:0]                rdPtr_r;
    logic [PTR_W:0]                  count_r;
    logic                            doPush_s;
    logic                            doPop_s;

    // A full queue refuses a push even when a pop happens in the same cycle.
    assign oFULL    = (count_r == (PTR_W+1)'(P_DEPTH));
    assign oEMPTY   = (count_r == '0);
    assign oCOUNT   = count_r;
    assign doPush_s = iPUSH && !oFULL;
    assign doPop_s  = iPOP && !oEMPTY;
    assign oDATA    = oEMPTY ? '0 : mem_r[rdPtr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            mem_r   <= '0;
            wrPtr_r <= '0;
            rdPtr_r <= '0;
            count_r <= '0;
        end else begin
            if (doPush_s) begin
                mem_r[wrPtr_r] <= iDATA;
                wrPtr_r        <= wrPtr_r + PTR_W'(1);
            end
            if (doPop_s) begin
                rdPtr_r <= rdPtr_r + PTR_W'(1);
            end
            case ({doPush_s, doPop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/gci_irq_arbiter_n.sv
// N-node interrupt arbiter: per-node level/edge trigger with enable mask, highest
// priority wins (lowest index on ties), winner index+1 queued for the CPU.
module gci_irq_arbiter_n
    import gci_irq_arbiter_n_pkg::*;
#(
    parameter int P_NODE_NUM    = 4,
    parameter int P_PRI_W       = 8,
    parameter int P_ENTRY_NUM   = 32,
    parameter int P_ENTRY_W     = 5,
    parameter int P_QUEUE_DEPTH = 4,
    parameter int P_NUM_W       = 6
) (
    input  logic                          iCLOCK,
    input  logic                          inRESET,
    gci_irq_arbiter_n_if.slave            bus,
    input  logic                          iNODEINF_VALID,
    input  logic [P_NODE_NUM*P_PRI_W-1:0] iNODE_PRIORITY,
    output logic                          oNODE_IRQ_BUSY,
    input  logic [P_NODE_NUM-1:0]         iNODE_IRQ,
    output logic [P_NODE_NUM-1:0]         oNODE_ACK
);
    irq_ctrl_t [P_ENTRY_NUM-1:0]      ctrlMem_r;
    logic [P_NODE_NUM-1:0]            pend_r;
    logic [P_NODE_NUM-1:0]            prevIrq_r;
    logic [P_NODE_NUM-1:0]            req_s;
    logic [P_NODE_NUM-1:0]            cand_s;
    logic [P_NODE_NUM-1:0]            beats_s;
    logic                             anyCand_s;
    logic [P_NUM_W-1:0]               winIdx_s;
    logic [P_PRI_W-1:0]               winPri_s;
    logic                             grant_s;
    logic                             qFull_s;
    logic                             qEmpty_s;
    logic                             qPop_s;
    logic [P_NUM_W-1:0]               qData_s;
    logic [$clog2(P_QUEUE_DEPTH):0]   qCount_s;
    logic                             unusedBits_s;

    // Control memory; arbitration in the write cycle still sees the old entry.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            ctrlMem_r <= '0;
        end else if (bus.irqCtrlReq) begin
            ctrlMem_r[bus.irqCtrlEntry] <= '{mask:  bus.irqCtrlInfoMask,
                                             valid: bus.irqCtrlInfoValid,
                                             mode:  bus.irqCtrlInfoMode};
        end
    end

    // Edge capture: a new rising edge outranks the clear from a grant in the same cycle.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            pend_r    <= '0;
            prevIrq_r <= '0;
        end else begin
            prevIrq_r <= iNODE_IRQ;
            for (int i = 0; i < P_NODE_NUM; i++) begin
                if (bus.irqCtrlReq && (bus.irqCtrlEntry == P_ENTRY_W'(i)) && !bus.irqCtrlInfoMode[0]) begin
                    pend_r[i] <= 1'b0;
                end else if (isEdgeMode(ctrlMem_r[i])) begin
                    pend_r[i] <= (iNODE_IRQ[i] && !prevIrq_r[i]) || (pend_r[i] && !oNODE_ACK[i]);
                end else begin
                    pend_r[i] <= 1'b0;
                end
            end
        end
    end

    // Winner search: strict greater-than keeps the lowest index among equal priorities.
    always_comb begin
        req_s     = '0;
        cand_s    = '0;
        beats_s   = '0;
        anyCand_s = 1'b0;
        winIdx_s  = '0;
        winPri_s  = '0;
        for (int i = 0; i < P_NODE_NUM; i++) begin
            req_s[i]   = isEdgeMode(ctrlMem_r[i]) ? pend_r[i] : iNODE_IRQ[i];
            cand_s[i]  = req_s[i] && isEnabled(ctrlMem_r[i]);
            beats_s[i] = cand_s[i] && (!anyCand_s || (iNODE_PRIORITY[i*P_PRI_W +: P_PRI_W] > winPri_s));
            winIdx_s   = beats_s[i] ? P_NUM_W'(i) : winIdx_s;
            winPri_s   = beats_s[i] ? iNODE_PRIORITY[i*P_PRI_W +: P_PRI_W] : winPri_s;
            anyCand_s  = anyCand_s || beats_s[i];
        end
    end

    assign oNODE_IRQ_BUSY = !iNODEINF_VALID || qFull_s;
    assign grant_s        = anyCand_s && !oNODE_IRQ_BUSY;

    // One-hot grant pulse towards the winning node.
    always_comb begin
        oNODE_ACK = '0;
        for (int i = 0; i < P_NODE_NUM; i++) begin
            oNODE_ACK[i] = grant_s && (winIdx_s == P_NUM_W'(i));
        end
    end

    assign bus.irqEmpty = qEmpty_s;
    assign bus.irqValid = !qEmpty_s && iNODEINF_VALID;
    assign bus.irqNum   = qData_s;
    assign qPop_s       = bus.irqAck && bus.irqValid;
    assign unusedBits_s = ^{qCount_s, ctrlMem_r};

    gci_irq_arbiter_n_queue #(
        .P_WIDTH (P_NUM_W),
        .P_DEPTH (P_QUEUE_DEPTH)
    ) uQueue (
        .iCLOCK  (iCLOCK),
        .inRESET (inRESET),
        .iPUSH   (grant_s),
        .iDATA   (winIdx_s + P_NUM_W'(1)),
        .iPOP    (qPop_s),
        .oDATA   (qData_s),
        .oFULL   (qFull_s),
        .oEMPTY  (qEmpty_s),
        .oCOUNT  (qCount_s)
    );

endmodule

// File: tb/tb_gci_irq_arbiter_n.sv
// Bench for gci_irq_arbiter_n: vector table, directed multi-cycle sequences,
// then randomized traffic against a queue-based reference model.
module tb_gci_irq_arbiter_n;
    localparam int N  = 4;
    localparam int PW = 8;
    localparam int EW = 5;
    localparam int QD = 4;
    localparam int NW = 6;

    logic          iCLOCK = 1'b0;
    logic          inRESET;
    logic          iNODEINF_VALID;
    logic [N*PW-1:0] iNODE_PRIORITY;
    logic          oNODE_IRQ_BUSY;
    logic [N-1:0]  iNODE_IRQ;
    logic [N-1:0]  oNODE_ACK;

    gci_irq_arbiter_n_if #(.P_ENTRY_W(EW), .P_NUM_W(NW)) bus ();

    gci_irq_arbiter_n #(
        .P_NODE_NUM(N), .P_PRI_W(PW), .P_ENTRY_NUM(32), .P_ENTRY_W(EW),
        .P_QUEUE_DEPTH(QD), .P_NUM_W(NW)
    ) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .bus(bus.slave),
        .iNODEINF_VALID(iNODEINF_VALID), .iNODE_PRIORITY(iNODE_PRIORITY),
        .oNODE_IRQ_BUSY(oNODE_IRQ_BUSY), .iNODE_IRQ(iNODE_IRQ), .oNODE_ACK(oNODE_ACK)
    );

    always #5 iCLOCK = ~iCLOCK;

    typedef struct packed {
        logic        ctrlWr;
        logic [4:0]  entry;
        logic        mask;
        logic [3:0]  irq;
        logic [31:0] pri;
        logic [3:0]  expAck;
        logic [5:0]  expNum;
    } vec_t;

    vec_t vecs[9];
    int   nCmp = 0;
    int   nFail = 0;
    int   drainExp[4] = '{2, 3, 4, 1};
    int   ackCnt;
    logic [3:0] ackSeen;

    // reference model state
    bit   mValid[N], mMask[N], mEdge[N], mPend[N], mPrev[N], mCand[N];
    int   mQ[$];
    int   maxPri, win;
    logic [3:0] expAck;
    logic expBusy, expValid;
    int   expNum;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic doReset();
        inRESET = 1'b0;
        iNODE_IRQ = 4'b0000;
        bus.irqAck = 1'b0;
        bus.irqCtrlReq = 1'b0;
        tick();
        tick();
        inRESET = 1'b1;
    endtask

    task automatic ctrlWrite(input logic [4:0] e, input logic m, input logic v, input logic [1:0] md);
        bus.irqCtrlReq       = 1'b1;
        bus.irqCtrlEntry     = e;
        bus.irqCtrlInfoMask  = m;
        bus.irqCtrlInfoValid = v;
        bus.irqCtrlInfoMode  = md;
        tick();
        bus.irqCtrlReq = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 5'd0,  1'b0, 4'b1111, 32'h0528280A, 4'b0010, 6'd2};
        vecs[1] = '{1'b1, 5'd1,  1'b0, 4'b1111, 32'h0528280A, 4'b0100, 6'd3};
        vecs[2] = '{1'b0, 5'd0,  1'b0, 4'b0000, 32'h0528280A, 4'b0000, 6'd0};
        vecs[3] = '{1'b0, 5'd0,  1'b0, 4'b1001, 32'h07000007, 4'b0001, 6'd1};
        vecs[4] = '{1'b0, 5'd0,  1'b0, 4'b1111, 32'hFFFEFEFE, 4'b1000, 6'd4};
        vecs[5] = '{1'b0, 5'd0,  1'b0, 4'b0110, 32'h00000000, 4'b0010, 6'd2};
        vecs[6] = '{1'b1, 5'd0,  1'b1, 4'b1111, 32'h646464C8, 4'b0001, 6'd1};
        vecs[7] = '{1'b1, 5'd1,  1'b0, 4'b0011, 32'h05050505, 4'b0001, 6'd1};
        vecs[8] = '{1'b1, 5'd20, 1'b0, 4'b1111, 32'h0528280A, 4'b0010, 6'd2};

        inRESET = 1'b0;
        iNODEINF_VALID = 1'b0;
        iNODE_IRQ = 4'b0000;
        iNODE_PRIORITY = 32'h0;
        bus.irqCtrlReq = 1'b0;
        bus.irqCtrlEntry = 5'd0;
        bus.irqCtrlInfoMask = 1'b0;
        bus.irqCtrlInfoValid = 1'b0;
        bus.irqCtrlInfoMode = 2'b00;
        bus.irqAck = 1'b0;

        // reset state
        @(negedge iCLOCK);
        chk("rst_empty", 32'(bus.irqEmpty), 32'd1);
        chk("rst_valid", 32'(bus.irqValid), 32'd0);
        chk("rst_ack",   32'(oNODE_ACK), 32'd0);
        chk("rst_num",   32'(bus.irqNum), 32'd0);
        chk("rst_busy_noinfo", 32'(oNODE_IRQ_BUSY), 32'd1);
        iNODEINF_VALID = 1'b1;
        #1;
        chk("rst_busy_info", 32'(oNODE_IRQ_BUSY), 32'd0);

        // vector table
        for (int v = 0; v < 9; v++) begin
            doReset();
            iNODEINF_VALID = 1'b1;
            if (vecs[v].ctrlWr) ctrlWrite(vecs[v].entry, vecs[v].mask, 1'b1, 2'b00);
            iNODE_PRIORITY = vecs[v].pri;
            iNODE_IRQ = vecs[v].irq;
            @(negedge iCLOCK);
            chk("vec_ack", 32'(oNODE_ACK), 32'(vecs[v].expAck));
            tick();
            iNODE_IRQ = 4'b0000;
            @(negedge iCLOCK);
            chk("vec_num", 32'(bus.irqNum), 32'(vecs[v].expNum));
            chk("vec_valid", 32'(bus.irqValid), 32'(vecs[v].expAck != 4'b0000));
            tick();
        end

        // edge mode: a held line yields exactly one grant
        doReset();
        iNODEINF_VALID = 1'b1;
        iNODE_PRIORITY = 32'h01010101;
        ctrlWrite(5'd0, 1'b1, 1'b1, 2'b01);
        ackCnt = 0;
        iNODE_IRQ = 4'b0001;
        for (int k = 0; k < 13; k++) begin
            @(negedge iCLOCK);
            if (oNODE_ACK != 4'b0000) ackCnt++;
            tick();
            if (k == 9) iNODE_IRQ = 4'b0000;
        end
        chk("edge_ack_count", 32'(ackCnt), 32'd1);
        @(negedge iCLOCK);
        chk("edge_num", 32'(bus.irqNum), 32'd1);
        bus.irqAck = 1'b1;
        tick();
        bus.irqAck = 1'b0;
        @(negedge iCLOCK);
        chk("edge_empty", 32'(bus.irqEmpty), 32'd1);

        // edge captured while busy, then edge->level->edge: pending edge dropped
        doReset();
        ctrlWrite(5'd0, 1'b1, 1'b1, 2'b01);
        iNODEINF_VALID = 1'b0;
        iNODE_IRQ = 4'b0001;
        tick();
        iNODE_IRQ = 4'b0000;
        tick();
        ctrlWrite(5'd0, 1'b1, 1'b1, 2'b00);
        ctrlWrite(5'd0, 1'b1, 1'b1, 2'b01);
        iNODEINF_VALID = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge iCLOCK);
            chk("modechg_ack", 32'(oNODE_ACK), 32'd0);
            tick();
        end

        // fill the queue, back-pressure, pop, drain order
        doReset();
        iNODEINF_VALID = 1'b1;
        iNODE_PRIORITY = 32'h10101010;
        iNODE_IRQ = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            @(negedge iCLOCK);
            chk("fill_ack", 32'(oNODE_ACK), 32'(4'b0001 << k));
            ackSeen = oNODE_ACK;
            tick();
            iNODE_IRQ = iNODE_IRQ & ~ackSeen;
        end
        iNODE_IRQ = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            @(negedge iCLOCK);
            chk("full_ack", 32'(oNODE_ACK), 32'd0);
            chk("full_busy", 32'(oNODE_IRQ_BUSY), 32'd1);
            tick();
        end
        bus.irqAck = 1'b1;
        @(negedge iCLOCK);
        chk("full_pop_ack", 32'(oNODE_ACK), 32'd0);
        chk("full_pop_num", 32'(bus.irqNum), 32'd1);
        tick();
        bus.irqAck = 1'b0;
        @(negedge iCLOCK);
        chk("after_pop_busy", 32'(oNODE_IRQ_BUSY), 32'd0);
        chk("after_pop_ack", 32'(oNODE_ACK), 32'd1);
        tick();
        iNODE_IRQ = 4'b0000;
        bus.irqAck = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge iCLOCK);
            chk("drain_num", 32'(bus.irqNum), 32'(drainExp[k]));
            tick();
        end
        bus.irqAck = 1'b0;
        @(negedge iCLOCK);
        chk("drain_empty", 32'(bus.irqEmpty), 32'd1);

        // node info invalid: busy, no grant, head hidden, ack ignored
        iNODE_IRQ = 4'b0100;
        @(negedge iCLOCK);
        chk("ninfo_pre_ack", 32'(oNODE_ACK), 32'b0100);
        tick();
        iNODEINF_VALID = 1'b0;
        iNODE_IRQ = 4'b0001;
        bus.irqAck = 1'b1;
        @(negedge iCLOCK);
        chk("ninfo_busy", 32'(oNODE_IRQ_BUSY), 32'd1);
        chk("ninfo_ack", 32'(oNODE_ACK), 32'd0);
        chk("ninfo_valid", 32'(bus.irqValid), 32'd0);
        chk("ninfo_empty", 32'(bus.irqEmpty), 32'd0);
        tick();
        bus.irqAck = 1'b0;
        iNODEINF_VALID = 1'b1;
        iNODE_IRQ = 4'b0000;
        @(negedge iCLOCK);
        chk("ninfo_kept_valid", 32'(bus.irqValid), 32'd1);
        chk("ninfo_kept_num", 32'(bus.irqNum), 32'd3);

        // randomized traffic against the reference model
        doReset();
        for (int j = 0; j < N; j++) begin
            mValid[j] = 1'($urandom);
            mMask[j]  = 1'($urandom);
            mEdge[j]  = 1'($urandom);
            ctrlWrite(5'(j), mMask[j], mValid[j], {1'($urandom), mEdge[j]});
            mPend[j] = 1'b0;
            mPrev[j] = 1'b0;
        end
        ctrlWrite(5'd17, 1'b0, 1'b1, 2'b01);
        mQ.delete();
        for (int c = 0; c < 400; c++) begin
            iNODE_IRQ = 4'($urandom);
            for (int j = 0; j < N; j++)
                iNODE_PRIORITY[j*PW +: PW] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 3));
            iNODEINF_VALID = ($urandom_range(0, 9) != 0);
            bus.irqAck = 1'($urandom);
            @(negedge iCLOCK);
            maxPri = -1;
            win = -1;
            for (int j = 0; j < N; j++) begin
                mCand[j] = (mEdge[j] ? mPend[j] : iNODE_IRQ[j]) && (!mValid[j] || mMask[j]);
                if (mCand[j] && int'(iNODE_PRIORITY[j*PW +: PW]) > maxPri) maxPri = int'(iNODE_PRIORITY[j*PW +: PW]);
            end
            for (int j = 0; j < N; j++)
                if (win < 0 && mCand[j] && int'(iNODE_PRIORITY[j*PW +: PW]) == maxPri) win = j;
            expBusy = !iNODEINF_VALID || (mQ.size() == QD);
            expAck = 4'b0000;
            if (win >= 0 && !expBusy) expAck[win] = 1'b1;
            expValid = (mQ.size() > 0) && iNODEINF_VALID;
            expNum = (mQ.size() > 0) ? mQ[0] : 0;
            chk("rnd_ack",   32'(oNODE_ACK), 32'(expAck));
            chk("rnd_busy",  32'(oNODE_IRQ_BUSY), 32'(expBusy));
            chk("rnd_valid", 32'(bus.irqValid), 32'(expValid));
            chk("rnd_num",   32'(bus.irqNum), expNum);
            chk("rnd_empty", 32'(bus.irqEmpty), 32'(mQ.size() == 0));
            if (bus.irqAck && expValid) void'(mQ.pop_front());
            if (expAck != 4'b0000) mQ.push_back(win + 1);
            for (int j = 0; j < N; j++) begin
                mPend[j] = mEdge[j] ? ((iNODE_IRQ[j] && !mPrev[j]) || (mPend[j] && !expAck[j])) : 1'b0;
                mPrev[j] = iNODE_IRQ[j];
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
